output_stream_tx: RTL

OUTPUT_STREAM_TX -- requirements
Module: output_stream_tx

---
 rtl/output_stream_tx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/output_stream_tx.sv
// Output-feature-map streamer: buffers result words in a small FWFT FIFO and hands them to a
// ready/valid sink, framing them with start/last/done. Optional OUTPUT_STREAM_ORDER_CHECK_EN adds order_error.
module output_stream_tx #(
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 4,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                          clk,
    input  logic                          arst_in,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [31:0]                   in_x,
    input  logic [31:0]                   in_y,
    input  logic [31:0]                   in_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [31:0]                   out_x,
    output logic [31:0]                   out_y,
    output logic [31:0]                   out_ch,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [31:0]                   tx_count
`ifdef OUTPUT_STREAM_ORDER_CHECK_EN
    ,
    output logic                          order_error
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [31:0]   LAST_X   = 32'(FEATURE_MAP_WIDTH - 1);
    localparam logic [31:0]   LAST_Y   = 32'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [31:0]   LAST_CH  = 32'(OUTPUT_NB_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [31:0]           r_mem_x    [FIFO_DEPTH];
    logic [31:0]           r_mem_y    [FIFO_DEPTH];
    logic [31:0]           r_mem_ch   [FIFO_DEPTH];
    logic                  r_mem_last [FIFO_DEPTH];

    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic [31:0]    r_tx_count;
    logic           r_overflow;
    logic           r_last_seen;
    logic           r_done;

    logic w_arm;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_is_last;
    logic w_full;

    assign w_full    = (r_level == FULL_LVL);
    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_arm     = (r_state == IDLE) && start;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push    = (r_state == RUN) && in_valid && (!w_full || w_pop);
    assign w_drop    = (r_state == RUN) && in_valid && w_full && !w_pop;
    assign w_is_last = (in_x == LAST_X) && (in_y == LAST_Y) && (in_ch == LAST_CH);

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_push && w_is_last) w_next_state = DRAIN;
            DRAIN:   if (w_pop && out_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_x[r_wr_ptr]    <= in_x;
            r_mem_y[r_wr_ptr]    <= in_y;
            r_mem_ch[r_wr_ptr]   <= in_ch;
            r_mem_last[r_wr_ptr] <= w_is_last;
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_tx_count  <= '0;
            r_overflow  <= 1'b0;
            r_last_seen <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == DRAIN) && w_pop && out_last;
            if (w_arm) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_level     <= '0;
                r_tx_count  <= '0;
                r_overflow  <= 1'b0;
                r_last_seen <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr   <= r_rd_ptr + AW'(1);
                    r_tx_count <= r_tx_count + 32'd1;
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + LW'(1);
                end else if (w_pop && !w_push) begin
                    r_level <= r_level - LW'(1);
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_push && w_is_last) begin
                    r_last_seen <= 1'b1;
                end
            end
        end
    end

    assign out_data = r_mem_data[r_rd_ptr];
    assign out_x    = r_mem_x[r_rd_ptr];
    assign out_y    = r_mem_y[r_rd_ptr];
    assign out_ch   = r_mem_ch[r_rd_ptr];
    // Gate with out_valid so a stale tag in an empty slot never leaks out.
    assign out_last = out_valid && r_mem_last[r_rd_ptr];
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;
    assign level    = r_level;
    assign tx_count = r_tx_count;

`ifdef OUTPUT_STREAM_ORDER_CHECK_EN
    logic [31:0] r_exp_x;
    logic [31:0] r_exp_y;
    logic [31:0] r_exp_ch;
    logic        r_order_error;
    logic [95:0] w_succ;

    function automatic logic [95:0] raster_next(input logic [31:0] x, input logic [31:0] y,
                                                input logic [31:0] ch);
        logic [31:0] nx;
        logic [31:0] ny;
        logic [31:0] nch;
        nx  = x + 32'd1;
        ny  = y;
        nch = ch;
        if (x == LAST_X) begin
            nx = '0;
            if (y == LAST_Y) begin
                ny  = '0;
                nch = ch + 32'd1;
            end else begin
                ny = y + 32'd1;
            end
        end
        return {nch, ny, nx};
    endfunction

    assign w_succ = raster_next(in_x, in_y, in_ch);

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_exp_x       <= '0;
            r_exp_y       <= '0;
            r_exp_ch      <= '0;
            r_order_error <= 1'b0;
        end else if (w_arm) begin
            r_exp_x       <= '0;
            r_exp_y       <= '0;
            r_exp_ch      <= '0;
            r_order_error <= 1'b0;
        end else if (w_push) begin
            if ((in_x != r_exp_x) || (in_y != r_exp_y) || (in_ch != r_exp_ch)) begin
                r_order_error <= 1'b1;
            end
            {r_exp_ch, r_exp_y, r_exp_x} <= w_succ;
        end
    end

    assign order_error = r_order_error;
`endif

endmodule
